// File: rtl/pcie_cpl_tx.sv
// PCIe completion-with-data TX: queues read completions, emits 3DW CplD TLPs.
// Define CPL_DATA_SWAP_EN to byte-swap the payload DW before transmit.
module pcie_cpl_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_tc,
  input  logic [1:0]  req_attr,
  input  logic [15:0] req_reqid,
  input  logic [7:0]  req_tag,
  input  logic [6:0]  req_addr,
  input  logic [31:0] req_data,
  input  logic [7:0]  cfg_bus_number,
  input  logic [4:0]  cfg_device_number,
  input  logic [2:0]  cfg_function_number,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        trn_tsrc_dsc_n,
  input  logic        trn_tdst_rdy_n
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [15:0] reqid;
    logic [7:0]  tag;
    logic [6:0]  addr;
    logic [31:0] data;
  } ent_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state, state_n;

  ent_t            mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            ready_en;
  ent_t            in_ent, head, pkt;
  logic [15:0]     cid;
  logic [31:0]     dsw;

  logic empty, full, push, avail, load, fifo_wr, fifo_rd, xfer;

  assign in_ent = '{tc: req_tc, attr: req_attr, reqid: req_reqid,
                    tag: req_tag, addr: req_addr, data: req_data};

  assign empty     = (count == '0);
  assign full      = (count == DEPTH);
  assign req_ready = ready_en & ~full;
  assign push      = req_valid & req_ready;
  // An empty FIFO is bypassed so a fresh request reaches HDR next cycle.
  assign avail     = ~empty | push;
  assign head      = empty ? in_ent : mem[rd_ptr];
  assign fifo_rd   = load & ~empty;
  assign fifo_wr   = push & ~(load & empty);
  assign xfer      = ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n;

  assign trn_trem_n     = 8'h00;
  assign trn_tsrc_dsc_n = 1'b1;

`ifdef CPL_DATA_SWAP_EN
  assign dsw = {pkt.data[7:0], pkt.data[15:8],
                pkt.data[23:16], pkt.data[31:24]};
`else
  assign dsw = pkt.data;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: load a packet on entry to HDR, advance only on transfer
  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (avail) begin
          state_n = HDR;
          load    = 1'b1;
        end
      end
      HDR: begin
        if (xfer) state_n = DATA;
      end
      DATA: begin
        if (xfer) begin
          if (avail) begin
            state_n = HDR;
            load    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Beat generation from the held packet and completer ID
  always_comb begin
    trn_td         = '0;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    unique case (state)
      HDR: begin
        trn_td = {1'b0, 7'b1001010, 1'b0, pkt.tc, 4'b0000,
                  2'b00, pkt.attr, 2'b00, 10'h001,
                  cid, 3'b000, 1'b0, 12'h004};
        trn_tsof_n     = 1'b0;
        trn_tsrc_rdy_n = 1'b0;
      end
      DATA: begin
        trn_td = {pkt.reqid, pkt.tag, 1'b0, pkt.addr, dsw};
        trn_teof_n     = 1'b0;
        trn_tsrc_rdy_n = 1'b0;
      end
      default: ;
    endcase
  end

  // FIFO pointers, occupancy and post-reset ready enable
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= in_ent;
  end

  // Held packet and completer ID, captured as HDR is loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt <= '0;
      cid <= '0;
    end else if (load) begin
      pkt <= head;
      cid <= {cfg_bus_number, cfg_device_number, cfg_function_number};
    end
  end

endmodule

// File: tb/tb_pcie_cpl_tx.sv
// Directed bench for pcie_cpl_tx: latency, stall hold, FIFO fill,
// back-to-back drain and mid-packet reset.
module tb_pcie_cpl_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_tc;
  logic [1:0]  req_attr;
  logic [15:0] req_reqid;
  logic [7:0]  req_tag;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic [7:0]  cfg_bus_number;
  logic [4:0]  cfg_device_number;
  logic [2:0]  cfg_function_number;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tsrc_dsc_n;
  logic        trn_tdst_rdy_n;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] hdr_e [5];
  logic [63:0] dat_e [5];

  pcie_cpl_tx #(.FIFO_DEPTH(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_tc              (req_tc),
    .req_attr            (req_attr),
    .req_reqid           (req_reqid),
    .req_tag             (req_tag),
    .req_addr            (req_addr),
    .req_data            (req_data),
    .cfg_bus_number      (cfg_bus_number),
    .cfg_device_number   (cfg_device_number),
    .cfg_function_number (cfg_function_number),
    .trn_td              (trn_td),
    .trn_trem_n          (trn_trem_n),
    .trn_tsof_n          (trn_tsof_n),
    .trn_teof_n          (trn_teof_n),
    .trn_tsrc_rdy_n      (trn_tsrc_rdy_n),
    .trn_tsrc_dsc_n      (trn_tsrc_dsc_n),
    .trn_tdst_rdy_n      (trn_tdst_rdy_n)
  );

  always #8 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] tc, input logic [1:0] attr,
                       input logic [7:0] tag, input logic [31:0] d);
    req_valid = 1'b1;
    req_tc    = tc;
    req_attr  = attr;
    req_reqid = 16'h0100;
    req_tag   = tag;
    req_addr  = 7'h04;
    req_data  = d;
  endtask

  task automatic chk_hdr(input string tag, input logic [63:0] exp);
    check({tag, ".td"},  trn_td, exp);
    check({tag, ".sof"}, 64'(trn_tsof_n), 64'd0);
    check({tag, ".eof"}, 64'(trn_teof_n), 64'd1);
    check({tag, ".rdy"}, 64'(trn_tsrc_rdy_n), 64'd0);
  endtask

  task automatic chk_dat(input string tag, input logic [63:0] exp);
    check({tag, ".td"},  trn_td, exp);
    check({tag, ".sof"}, 64'(trn_tsof_n), 64'd1);
    check({tag, ".eof"}, 64'(trn_teof_n), 64'd0);
    check({tag, ".rdy"}, 64'(trn_tsrc_rdy_n), 64'd0);
  endtask

`ifdef CPL_DATA_SWAP_EN
  localparam logic [63:0] DAT1 = 64'h01000504_44332211;
`else
  localparam logic [63:0] DAT1 = 64'h01000504_11223344;
`endif
  localparam logic [63:0] HDR1 = 64'h4A000001_01000004;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_tc = '0; req_attr = '0; req_reqid = '0;
    req_tag = '0; req_addr = '0; req_data = '0;
    cfg_bus_number = 8'd1;
    cfg_device_number = 5'd0;
    cfg_function_number = 3'd0;
    trn_tdst_rdy_n = 1'b0;

    hdr_e[0] = HDR1;
    hdr_e[1] = HDR1;
    hdr_e[2] = 64'h4A302001_01000004;
    hdr_e[3] = HDR1;
    hdr_e[4] = HDR1;
`ifdef CPL_DATA_SWAP_EN
    dat_e[0] = 64'h01001004_000000A0;
    dat_e[1] = 64'h01001104_010000A0;
    dat_e[2] = 64'h01001204_020000A0;
    dat_e[3] = 64'h01001304_030000A0;
    dat_e[4] = 64'h01001404_040000A0;
`else
    dat_e[0] = 64'h01001004_A0000000;
    dat_e[1] = 64'h01001104_A0000001;
    dat_e[2] = 64'h01001204_A0000002;
    dat_e[3] = 64'h01001304_A0000003;
    dat_e[4] = 64'h01001404_A0000004;
`endif

    // reset state
    repeat (2) @(negedge clk);
    check("rst.rdy",   64'(trn_tsrc_rdy_n), 64'd1);
    check("rst.sof",   64'(trn_tsof_n), 64'd1);
    check("rst.eof",   64'(trn_teof_n), 64'd1);
    check("rst.td",    trn_td, 64'd0);
    check("rst.ready", 64'(req_ready), 64'd0);
    check("rst.trem",  64'(trn_trem_n), 64'd0);
    check("rst.dsc",   64'(trn_tsrc_dsc_n), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("post.ready", 64'(req_ready), 64'd1);

    // single completion, destination always ready
    drive(3'd0, 2'd0, 8'h05, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b0;
    chk_hdr("t1.hdr", HDR1);
    @(negedge clk);
    chk_dat("t1.dat", DAT1);
    @(negedge clk);
    check("t1.idle", 64'(trn_tsrc_rdy_n), 64'd1);

    // header held through a 5-cycle stall; cfg change must not leak in
    trn_tdst_rdy_n = 1'b1;
    drive(3'd0, 2'd0, 8'h05, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b0;
    cfg_bus_number = 8'd2;
    for (int i = 0; i < 5; i++) begin
      chk_hdr($sformatf("t2.hold%0d", i), HDR1);
      if (i == 4) trn_tdst_rdy_n = 1'b0;
      @(negedge clk);
    end
    cfg_bus_number = 8'd1;
    chk_dat("t2.dat", DAT1);
    @(negedge clk);
    check("t2.idle", 64'(trn_tsrc_rdy_n), 64'd1);

    // fill: one into the held register, four into the FIFO
    trn_tdst_rdy_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3.ready%0d", i), 64'(req_ready), 64'd1);
      drive((i == 2) ? 3'd3 : 3'd0, (i == 2) ? 2'd2 : 2'd0,
            8'h10 + 8'(i), 32'hA0000000 + 32'(i));
      @(negedge clk);
    end
    check("t3.full", 64'(req_ready), 64'd0);
    drive(3'd0, 2'd0, 8'h99, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    check("t3.full2", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    trn_tdst_rdy_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_hdr($sformatf("t3.hdr%0d", k), hdr_e[k]);
      @(negedge clk);
      chk_dat($sformatf("t3.dat%0d", k), dat_e[k]);
      @(negedge clk);
    end
    check("t3.idle", 64'(trn_tsrc_rdy_n), 64'd1);
    check("t3.ready", 64'(req_ready), 64'd1);

    // reset during DATA with two entries queued
    trn_tdst_rdy_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'd0, 2'd0, 8'h10 + 8'(i), 32'hA0000000 + 32'(i));
      @(negedge clk);
    end
    req_valid = 1'b0;
    trn_tdst_rdy_n = 1'b0;
    chk_hdr("t4.hdr", hdr_e[0]);
    @(negedge clk);
    chk_dat("t4.dat", dat_e[0]);
    rst = 1'b1;
    @(negedge clk);
    check("t4.rdy",   64'(trn_tsrc_rdy_n), 64'd1);
    check("t4.eof",   64'(trn_teof_n), 64'd1);
    check("t4.td",    trn_td, 64'd0);
    check("t4.ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t4.quiet%0d", i), 64'(trn_tsrc_rdy_n), 64'd1);
    end
    check("t4.ready1", 64'(req_ready), 64'd1);

    // queue survives nothing: a new request after reset still works
    drive(3'd0, 2'd0, 8'h05, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b0;
    chk_hdr("t5.hdr", HDR1);
    @(negedge clk);
    chk_dat("t5.dat", DAT1);
    @(negedge clk);
    check("t5.idle", 64'(trn_tsrc_rdy_n), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pcie_cpl_tx.md
PCIE_CPL_TX -- requirements
Module: pcie_cpl_tx

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, request FIFO entries (power of two, 2..16).
REQ-002 SHALL have port: clk  input  1  62.5 MHz transaction clock; sole clock.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  completion request present.
REQ-005 SHALL have port: req_ready  output  1  request FIFO can accept.
REQ-006 SHALL have port: req_tc  input  3  traffic class of originating MRd.
REQ-007 SHALL have port: req_attr  input  2  attributes of originating MRd.
REQ-008 SHALL have port: req_reqid  input  16  requester ID.
REQ-009 SHALL have port: req_tag  input  8  request tag.
REQ-010 SHALL have port: req_addr  input  7  lower address, byte units.
REQ-011 SHALL have port: req_data  input  32  read data DW, host byte order before swap.
REQ-012 SHALL have ports: cfg_bus_number  input  8; cfg_device_number  input  5; cfg_function_number  input  3; completer ID.
REQ-013 SHALL have ports: trn_td  output  64; trn_trem_n  output  8; trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n  output  1 each; trn_tdst_rdy_n  input  1; Local-Link TX to endpoint core.

Function
REQ-014 SHALL push {tc,attr,reqid,tag,addr,data} into the FIFO when req_valid & req_ready; req_ready = FIFO not full.
REQ-015 SHALL run FSM IDLE -> HDR -> DATA; IDLE->HDR when FIFO non-empty, popping one entry into a held packet register on that transition.
REQ-016 HDR beat: trn_td = {0, 7'b1001010, 0, tc, 4'b0, 2'b00, attr, 2'b00, 10'h001, bus, dev, fn, 3'b000, 0, 12'h004}; trn_tsof_n=0, trn_teof_n=1.
REQ-017 DATA beat: trn_td = {reqid, tag, 0, addr, data'}; trn_tsof_n=1, trn_teof_n=0.
REQ-018 trn_tsrc_rdy_n SHALL be 0 exactly in HDR and DATA; a beat transfers when trn_tsrc_rdy_n=0 and trn_tdst_rdy_n=0.
REQ-019 While trn_tdst_rdy_n=1, trn_td, trn_tsof_n, trn_teof_n SHALL hold stable and state SHALL not advance.
REQ-020 On DATA transfer SHALL go to HDR (popping next entry) if FIFO non-empty, else IDLE; no idle cycle between back-to-back completions.
REQ-021 Latency: request accepted in cycle N into empty FIFO while IDLE -> HDR beat presented in cycle N+1.
REQ-022 Simultaneous push and pop SHALL both occur; occupancy unchanged; when full, pop in a cycle SHALL not make req_ready high until the next cycle.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; no overwrite when full, no pop when empty.
REQ-024 trn_trem_n SHALL be constant 8'h00; trn_tsrc_dsc_n constant 1.
REQ-025 Completer ID SHALL be sampled from cfg_* when the HDR beat is loaded.

Reset
REQ-026 While rst=1 at a clock edge: FSM=IDLE, FIFO emptied, trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_td=0, req_ready=0.
REQ-027 First cycle after rst deasserts: req_ready=1.
REQ-028 Reset mid-packet SHALL abandon the TLP (no teof) and discard all queued requests.

Configuration
REQ-029 Macro CPL_DATA_SWAP_EN defined: data' = {data[7:0],data[15:8],data[23:16],data[31:24]}.
REQ-030 Macro CPL_DATA_SWAP_EN undefined: data' = data unchanged.

Verification
REQ-031 Single request tc=0, attr=0, reqid=16'h0100, tag=8'h05, addr=7'h04, data=32'h11223344, bus/dev/fn=1/0/0, dst always ready -> HDR 64'h4A000001_01000004 at N+1, DATA 64'h01000504_44332211 (swap on) at N+2.
REQ-032 Same request, trn_tdst_rdy_n=1 for 5 cycles at HDR -> HDR held unchanged 5 cycles, DATA follows one cycle after release.
REQ-033 Push 5 requests back-to-back, depth 4, dst stalled -> req_ready low after 4 pushes plus one popped into the held register; all 5 completions later emitted in order, 10 consecutive beats.
REQ-034 rst pulsed during DATA beat with 2 entries queued -> tsrc_rdy_n=1 next cycle, no further beats, req_ready=1 after release.
REQ-035 Macro undefined, data=32'h11223344 -> DATA low DW 32'h11223344.
